// File: rtl/imuldiv_muldiv_dispatch.sv
// Mul/div request dispatcher: routes each request from the single processor
// port to the multiply or divide unit and records a tag for it. Responses are
// returned strictly in issue order through a registered response port.
module imuldiv_muldiv_dispatch #(
  parameter int TAG_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  muldivreq_msg_fn,
  input  logic [31:0] muldivreq_msg_a,
  input  logic [31:0] muldivreq_msg_b,
  input  logic        muldivreq_val,
  output logic        muldivreq_rdy,
  output logic [31:0] mulreq_msg_a,
  output logic [31:0] mulreq_msg_b,
  output logic        mulreq_val,
  input  logic        mulreq_rdy,
  input  logic [63:0] mulresp_msg_result,
  input  logic        mulresp_val,
  output logic        mulresp_rdy,
  output logic        divreq_msg_fn,
  output logic [31:0] divreq_msg_a,
  output logic [31:0] divreq_msg_b,
  output logic        divreq_val,
  input  logic        divreq_rdy,
  input  logic [63:0] divresp_msg_result,
  input  logic        divresp_val,
  output logic        divresp_rdy,
  output logic [31:0] muldivresp_msg_result,
  output logic        muldivresp_val,
  input  logic        muldivresp_rdy
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  // Divide unit function encoding: 0 = signed, 1 = unsigned
  localparam logic DIV_FN_SIGNED   = 1'b0;
  localparam logic DIV_FN_UNSIGNED = 1'b1;

  typedef enum logic [1:0] {
    SRC_MUL  = 2'd0,
    SRC_DIV  = 2'd1,
    SRC_ZERO = 2'd2
  } src_e;

  src_e             tag_src_r [TAG_DEPTH];
  logic             tag_hi_r  [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [31:0]      result_r;
  logic             resp_val_r;

  logic        is_mul_s;
  logic        is_div_s;
  src_e        req_src_s;
  logic        req_hi_s;
  logic        div_fn_s;
  logic        full_s;
  logic        empty_s;
  logic        req_rdy_s;
  logic        push_s;
  logic        pop_s;
  logic        load_ok_s;
  logic [31:0] load_data_s;
  logic        mul_rdy_s;
  logic        div_rdy_s;
  src_e        head_src_s;
  logic        head_hi_s;

  assign full_s     = (count_r == FULL_CNT);
  assign empty_s    = (count_r == {CNT_W{1'b0}});
  assign head_src_s = tag_src_r[rd_ptr_r];
  assign head_hi_s  = tag_hi_r[rd_ptr_r];
  assign load_ok_s  = ~resp_val_r | muldivresp_rdy;

  // Decode the function code into a target unit, tag and divider mode
  always_comb begin
    is_mul_s  = 1'b0;
    is_div_s  = 1'b0;
    req_src_s = SRC_ZERO;
    req_hi_s  = 1'b0;
    div_fn_s  = DIV_FN_SIGNED;
    case (muldivreq_msg_fn)
      FN_MUL:  begin is_mul_s = 1'b1; req_src_s = SRC_MUL; end
      FN_DIV:  begin is_div_s = 1'b1; req_src_s = SRC_DIV; end
      FN_DIVU: begin is_div_s = 1'b1; req_src_s = SRC_DIV; div_fn_s = DIV_FN_UNSIGNED; end
      FN_REM:  begin is_div_s = 1'b1; req_src_s = SRC_DIV; req_hi_s = 1'b1; end
      FN_REMU: begin is_div_s = 1'b1; req_src_s = SRC_DIV; req_hi_s = 1'b1; div_fn_s = DIV_FN_UNSIGNED; end
      default: begin is_mul_s = 1'b0; is_div_s = 1'b0; end
    endcase
  end

  // Request ready: tag space first, then the selected unit; illegal ops need only tag space
  always_comb begin
    if (full_s) begin
      req_rdy_s = 1'b0;
    end else if (is_mul_s) begin
      req_rdy_s = mulreq_rdy;
    end else if (is_div_s) begin
      req_rdy_s = divreq_rdy;
    end else begin
      req_rdy_s = 1'b1;
    end
  end

  assign muldivreq_rdy = req_rdy_s;
  assign push_s        = muldivreq_val & req_rdy_s;
  assign mulreq_msg_a  = muldivreq_msg_a;
  assign mulreq_msg_b  = muldivreq_msg_b;
  assign mulreq_val    = muldivreq_val & is_mul_s & ~full_s;
  assign divreq_msg_fn = div_fn_s;
  assign divreq_msg_a  = muldivreq_msg_a;
  assign divreq_msg_b  = muldivreq_msg_b;
  assign divreq_val    = muldivreq_val & is_div_s & ~full_s;

  // Head-of-FIFO response steering: only the unit named by the head tag may hand over
  always_comb begin
    mul_rdy_s   = 1'b0;
    div_rdy_s   = 1'b0;
    pop_s       = 1'b0;
    load_data_s = 32'd0;
    if (!empty_s) begin
      case (head_src_s)
        SRC_MUL: begin
          mul_rdy_s   = load_ok_s;
          pop_s       = load_ok_s & mulresp_val;
          load_data_s = head_hi_s ? mulresp_msg_result[63:32] : mulresp_msg_result[31:0];
        end
        SRC_DIV: begin
          div_rdy_s   = load_ok_s;
          pop_s       = load_ok_s & divresp_val;
          load_data_s = head_hi_s ? divresp_msg_result[63:32] : divresp_msg_result[31:0];
        end
        default: begin
          // ZERO ops (and any unexpected tag value) retire with a zero result
          pop_s       = load_ok_s;
          load_data_s = 32'd0;
        end
      endcase
    end else begin
      pop_s = 1'b0;
    end
  end

  assign mulresp_rdy = mul_rdy_s;
  assign divresp_rdy = div_rdy_s;

  // Tag FIFO: write on request fire, read on output load, occupancy count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_src_r[i] <= SRC_ZERO;
        tag_hi_r[i]  <= 1'b0;
      end
    end else begin
      if (push_s) begin
        tag_src_r[wr_ptr_r] <= req_src_s;
        tag_hi_r[wr_ptr_r]  <= req_hi_s;
        wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered response port: load wins over drain so back-to-back results stream
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_r   <= 32'd0;
      resp_val_r <= 1'b0;
    end else if (pop_s) begin
      result_r   <= load_data_s;
      resp_val_r <= 1'b1;
    end else if (resp_val_r && muldivresp_rdy) begin
      resp_val_r <= 1'b0;
    end
  end

  assign muldivresp_msg_result = result_r;
  assign muldivresp_val        = resp_val_r;

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
// Directed bench for the mul/div dispatcher with queue-based unit models.
module tb_imuldiv_muldiv_dispatch;

  logic        clk;
  logic        reset_n;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a;
  logic [31:0] muldivreq_msg_b;
  logic        muldivreq_val;
  logic        muldivreq_rdy;
  logic [31:0] mulreq_msg_a;
  logic [31:0] mulreq_msg_b;
  logic        mulreq_val;
  logic        mulreq_rdy;
  logic [63:0] mulresp_msg_result;
  logic        mulresp_val;
  logic        mulresp_rdy;
  logic        divreq_msg_fn;
  logic [31:0] divreq_msg_a;
  logic [31:0] divreq_msg_b;
  logic        divreq_val;
  logic        divreq_rdy;
  logic [63:0] divresp_msg_result;
  logic        divresp_val;
  logic        divresp_rdy;
  logic [31:0] muldivresp_msg_result;
  logic        muldivresp_val;
  logic        muldivresp_rdy;

  imuldiv_muldiv_dispatch #(.TAG_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
    .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val), .muldivreq_rdy(muldivreq_rdy),
    .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b), .mulreq_val(mulreq_val), .mulreq_rdy(mulreq_rdy),
    .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val), .mulresp_rdy(mulresp_rdy),
    .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
    .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
    .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(divresp_rdy),
    .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val),
    .muldivresp_rdy(muldivresp_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Unit models: always accept, respond from an in-order queue when enabled
  logic        mul_en, div_en;
  logic [63:0] mq [16];
  logic [63:0] dq [16];
  logic [4:0]  mq_wr, mq_rd, dq_wr, dq_rd;
  int          n_mulreq = 0;
  int          n_divreq = 0;

  assign mulreq_rdy         = 1'b1;
  assign divreq_rdy         = 1'b1;
  assign mulresp_val        = mul_en && (mq_wr != mq_rd);
  assign mulresp_msg_result = mq[mq_rd[3:0]];
  assign divresp_val        = div_en && (dq_wr != dq_rd);
  assign divresp_msg_result = dq[dq_rd[3:0]];

  function automatic logic [63:0] div_model(input logic fn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (fn == 1'b0) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq_wr <= 5'd0; mq_rd <= 5'd0; dq_wr <= 5'd0; dq_rd <= 5'd0;
    end else begin
      if (mulreq_val && mulreq_rdy) begin
        mq[mq_wr[3:0]] <= {32'd0, mulreq_msg_a} * {32'd0, mulreq_msg_b};
        mq_wr <= mq_wr + 5'd1;
        n_mulreq <= n_mulreq + 1;
      end
      if (mulresp_val && mulresp_rdy) mq_rd <= mq_rd + 5'd1;
      if (divreq_val && divreq_rdy) begin
        dq[dq_wr[3:0]] <= div_model(divreq_msg_fn, divreq_msg_a, divreq_msg_b);
        dq_wr <= dq_wr + 5'd1;
        n_divreq <= n_divreq + 1;
      end
      if (divresp_val && divresp_rdy) dq_rd <= dq_rd + 5'd1;
    end
  end

  // Response collector
  logic [31:0] got [64];
  int          n_got = 0;
  always @(posedge clk) begin
    if (reset_n && muldivresp_val && muldivresp_rdy) begin
      got[n_got % 64] <= muldivresp_msg_result;
      n_got <= n_got + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Offer one request (caller is at a negedge); checks routing at the fire cycle
  task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    int w;
    muldivreq_msg_fn = fn;
    muldivreq_msg_a  = a;
    muldivreq_msg_b  = b;
    muldivreq_val    = 1'b1;
    #1;
    w = 0;
    while (!muldivreq_rdy && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("issue_rdy", {31'd0, muldivreq_rdy}, 32'd1);
    if (fn == 3'd0) begin
      check("mulreq_val", {31'd0, mulreq_val}, 32'd1);
      check("mul_no_divreq", {31'd0, divreq_val}, 32'd0);
    end else if (fn <= 3'd4) begin
      check("divreq_val", {31'd0, divreq_val}, 32'd1);
      check("divreq_fn", {31'd0, divreq_msg_fn}, (fn == 3'd1 || fn == 3'd3) ? 32'd0 : 32'd1);
    end else begin
      check("illegal_no_req", {30'd0, mulreq_val, divreq_val}, 32'd0);
    end
    @(negedge clk);
    muldivreq_val = 1'b0;
  endtask

  task automatic wait_got(input int target);
    int w;
    w = 0;
    while (n_got < target && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("resp_count", 32'(n_got), 32'(target));
  endtask

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];
  int   base;
  int   acc;
  logic fire;

  initial begin
    vecs[0]  = '{3'd0, 32'd7,          32'd6,       32'd42};
    vecs[1]  = '{3'd0, 32'hFFFFFFFF,   32'd2,       32'hFFFFFFFE};
    vecs[2]  = '{3'd1, 32'hFFFFFFF9,   32'd2,       32'hFFFFFFFD};
    vecs[3]  = '{3'd3, 32'hFFFFFFF9,   32'd2,       32'hFFFFFFFF};
    vecs[4]  = '{3'd2, 32'd7,          32'd2,       32'd3};
    vecs[5]  = '{3'd4, 32'd7,          32'd2,       32'd1};
    vecs[6]  = '{3'd5, 32'd5,          32'd5,       32'd0};
    vecs[7]  = '{3'd7, 32'd1,          32'd1,       32'd0};
    vecs[8]  = '{3'd2, 32'hFFFFFFF9,   32'd2,       32'h7FFFFFFC};
    vecs[9]  = '{3'd3, 32'd100,        32'd7,       32'd2};
    vecs[10] = '{3'd0, 32'h00010000,   32'h00010000, 32'd0};
    vecs[11] = '{3'd0, 32'h00012345,   32'd16,      32'h00123450};

    reset_n = 1'b0;
    muldivreq_msg_fn = 3'd0; muldivreq_msg_a = 32'd0; muldivreq_msg_b = 32'd0;
    muldivreq_val = 1'b0; muldivresp_rdy = 1'b1; mul_en = 1'b1; div_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_resp_val", {31'd0, muldivresp_val}, 32'd0);
    check("rst_resp_result", muldivresp_msg_result, 32'd0);
    check("rst_count", 32'(dut.count_r), 32'd0);
    check("rst_unit_vals", {30'd0, mulreq_val, divreq_val}, 32'd0);
    check("rst_resp_rdys", {30'd0, mulresp_rdy, divresp_rdy}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Latency: 42 appears one cycle after the mul response handshake
    mul_en = 1'b0;
    issue(3'd0, 32'd7, 32'd6);
    @(negedge clk);
    check("lat_held_val", {31'd0, muldivresp_val}, 32'd0);
    mul_en = 1'b1;
    #1;
    check("lat_mulresp_rdy", {31'd0, mulresp_rdy}, 32'd1);
    @(negedge clk);
    check("lat_val", {31'd0, muldivresp_val}, 32'd1);
    check("lat_result", muldivresp_msg_result, 32'd42);
    @(negedge clk);

    // Table: one op at a time
    for (int i = 0; i < 12; i++) begin
      base = n_got;
      issue(vecs[i].fn, vecs[i].a, vecs[i].b);
      wait_got(base + 1);
      check($sformatf("vec%0d", i), got[base % 64], vecs[i].exp);
    end

    // Back-to-back DIV/REM/DIVU/REMU
    base = n_got;
    for (int i = 2; i < 6; i++) issue(vecs[i].fn, vecs[i].a, vecs[i].b);
    wait_got(base + 4);
    for (int i = 0; i < 4; i++) check($sformatf("b2b%0d", i), got[(base + i) % 64], vecs[i + 2].exp);

    // In-order completion: mul finishes first but waits for the div ahead of it
    div_en = 1'b0;
    base = n_got;
    issue(3'd1, 32'd100, 32'd10);
    issue(3'd0, 32'd3, 32'd3);
    @(negedge clk);
    @(negedge clk);
    check("order_mul_pending", {31'd0, mulresp_val}, 32'd1);
    check("order_mul_held", {31'd0, mulresp_rdy}, 32'd0);
    div_en = 1'b1;
    wait_got(base + 2);
    check("order_first", got[base % 64], 32'd10);
    check("order_second", got[(base + 1) % 64], 32'd9);

    // Full FIFO with a stalled output port
    muldivresp_rdy = 1'b0;
    base = n_got;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      muldivreq_msg_fn = 3'd0;
      muldivreq_msg_a  = 32'(acc + 1);
      muldivreq_msg_b  = 32'd11;
      muldivreq_val    = 1'b1;
      #1;
      fire = muldivreq_rdy;
      @(negedge clk);
      if (fire) acc++;
    end
    muldivreq_val = 1'b0;
    #1;
    check("full_accepted", 32'(acc), 32'd5);
    check("full_rdy_low", {31'd0, muldivreq_rdy}, 32'd0);
    check("full_count", 32'(dut.count_r), 32'd4);
    check("full_out_val", {31'd0, muldivresp_val}, 32'd1);
    check("full_out_data", muldivresp_msg_result, 32'd11);
    @(negedge clk);
    muldivresp_rdy = 1'b1;
    issue(3'd0, 32'd6, 32'd11);
    wait_got(base + 6);
    for (int i = 0; i < 6; i++) check($sformatf("full_res%0d", i), got[(base + i) % 64], 32'((i + 1) * 11));

    // Illegal op between two MULs: returns zero, no unit request
    base = n_got;
    acc = n_divreq;
    fire = 1'b0;
    issue(3'd0, 32'd2, 32'd2);
    issue(3'd6, 32'd5, 32'd5);
    issue(3'd0, 32'd2, 32'd2);
    wait_got(base + 3);
    check("ill_0", got[base % 64], 32'd4);
    check("ill_1", got[(base + 1) % 64], 32'd0);
    check("ill_2", got[(base + 2) % 64], 32'd4);
    check("ill_no_div", 32'(n_divreq - acc), 32'd0);

    // Asynchronous reset with outstanding work
    muldivresp_rdy = 1'b0;
    acc = n_mulreq;
    for (int i = 0; i < 4; i++) issue(3'd0, 32'(i + 1), 32'd3);
    @(negedge clk);
    check("rstmid_mulreqs", 32'(n_mulreq - acc), 32'd4);
    check("rstmid_pre_val", {31'd0, muldivresp_val}, 32'd1);
    check("rstmid_pre_count", 32'(dut.count_r), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid_val", {31'd0, muldivresp_val}, 32'd0);
    check("rstmid_count", 32'(dut.count_r), 32'd0);
    check("rstmid_result", muldivresp_msg_result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    muldivresp_rdy = 1'b1;
    @(negedge clk);
    base = n_got;
    issue(3'd0, 32'd2, 32'd5);
    wait_got(base + 1);
    check("post_rst_mul", got[base % 64], 32'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imuldiv_muldiv_dispatch.md
Name: imuldiv_muldiv_dispatch

Overview:
- Front-end between the processor's single mul/div request port and the separate iterative multiply and divide units.
- Decodes a 3-bit function code and routes each request to the correct unit.
- Records every accepted operation in an in-order tag FIFO.
- Consumes unit responses strictly in issue order, selects the required 32-bit half of the 64-bit result, and returns it through a registered response port.

Parameters:
TAG_DEPTH, 4, max outstanding ops held in the tag FIFO; power of 2, >=2

Ports:
clk  in  1  clock
reset_n  in  1  reset
muldivreq_msg_fn  in  3  0=MUL 1=DIV 2=DIVU 3=REM 4=REMU; 5-7 illegal
muldivreq_msg_a  in  32  operand A
muldivreq_msg_b  in  32  operand B
muldivreq_val  in  1  request valid
muldivreq_rdy  out  1  request ready
mulreq_msg_a  out  32  operand A to mul unit
mulreq_msg_b  out  32  operand B to mul unit
mulreq_val  out  1  mul request valid
mulreq_rdy  in  1  mul request ready
mulresp_msg_result  in  64  mul product {hi,lo}
mulresp_val  in  1  mul response valid
mulresp_rdy  out  1  mul response ready
divreq_msg_fn  out  1  signed/unsigned select, using the existing DIVREQ_MSG_FUNC encoding
divreq_msg_a  out  32  operand A to div unit
divreq_msg_b  out  32  operand B to div unit
divreq_val  out  1  div request valid
divreq_rdy  in  1  div request ready
divresp_msg_result  in  64  {remainder,quotient}
divresp_val  in  1  div response valid
divresp_rdy  out  1  div response ready
muldivresp_msg_result  out  32  selected result
muldivresp_val  out  1  response valid
muldivresp_rdy  in  1  response ready

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous and active-low.
- Reset state:
  - Tag FIFO empty: count=0, read and write pointers 0.
  - muldivresp_val=0 and muldivresp_msg_result=0.
  - All *_val outputs are 0 during and after reset until driven by the rules below.
  - Reset mid-operation discards all outstanding tags. Units are reset by the same reset_n, so nothing is re-issued.
- Tag contents: src (MUL, DIV, ZERO) plus hi (1 selects result[63:32], 0 selects result[31:0]).
- Request decode and tag per function code:
  - MUL: src=MUL, hi=0.
  - DIV: src=DIV, hi=0, signed.
  - DIVU: src=DIV, hi=0, unsigned.
  - REM: src=DIV, hi=1, signed.
  - REMU: src=DIV, hi=1, unsigned.
  - Codes 5-7: src=ZERO; no unit request is issued.
- Operands pass through to both units combinationally.
- mulreq_val = muldivreq_val & is_mul & !full.
- divreq_val = muldivreq_val & is_div & !full.
- muldivreq_rdy = !full & (is_mul ? mulreq_rdy : is_div ? divreq_rdy : 1).
- Request fire (muldivreq_val & muldivreq_rdy) pushes the tag. No combinational path from unit rdy into the FIFO state other than through the fire term.
- When full (count==TAG_DEPTH), push is blocked even if a pop happens in the same cycle; rdy depends only on the registered count.
- Response side, per head tag, when FIFO is non-empty:
  - load_ok = !muldivresp_val | muldivresp_rdy.
  - head src=MUL: mulresp_rdy = load_ok; divresp_rdy = 0.
  - head src=DIV: divresp_rdy = load_ok; mulresp_rdy = 0.
  - head src=ZERO: no unit handshake; the head is loadable whenever load_ok.
  - Any unit response whose src does not match the head is held off with rdy=0, which enforces in-order completion.
- Load event (head handshake, or ZERO head with load_ok):
  - Output register takes the selected half, or 0 for ZERO.
  - muldivresp_val is set to 1 and the tag is popped.
- Latency: result is visible on muldivresp 1 cycle after the unit response handshake; ZERO ops return 1 cycle after reaching the FIFO head.
- Output drained (muldivresp_val & muldivresp_rdy) with no load in the same cycle clears muldivresp_val.
- Load and drain in the same cycle keep muldivresp_val=1 with new data, giving full throughput.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Pointers wrap modulo TAG_DEPTH. count width is clog2(TAG_DEPTH)+1.
- An empty FIFO forces mulresp_rdy = divresp_rdy = 0.

Test Plan:
- Reset, then MUL a=7 b=6, units respond promptly -> muldivresp_msg_result=42 one cycle after the mul handshake; then MUL a=0xFFFFFFFF b=2 -> 0xFFFFFFFE (low word).
- DIV a=-7 b=2, REM a=-7 b=2, DIVU a=7 b=2, REMU a=7 b=2 back-to-back -> 0xFFFFFFFD, 0xFFFFFFFF, 3, 1 in order; divreq_msg_fn is signed/signed/unsigned/unsigned.
- Issue DIV 100/10 then MUL 3*3 where the mul unit responds before div -> mulresp_rdy held 0 until the div result 10 loads; outputs are 10 then 9.
- With muldivresp_rdy=0, issue TAG_DEPTH+2 MULs -> muldivreq_rdy drops once 4 tags are outstanding; release rdy -> all results in order, pointers wrap correctly, no loss.
- fn=6 a=5 b=5 between two MULs 2*2 -> outputs 4, 0, 4; no mulreq/divreq is issued for the illegal op.
- Pulse reset_n low asynchronously while 3 ops are outstanding and muldivresp_val=1 -> muldivresp_val=0 immediately, FIFO empty, and a subsequent MUL 2*5 returns 10.
